inert_sensor_resp: RTL and testbench



---
 rtl/inert_resp_pkg.sv | 28 ++
 rtl/inert_sensor_resp_if.sv | 35 +++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/inert_sensor_resp.sv | 190 +++++++++++++++++++
 tb/tb_inert_sensor_resp.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/inert_resp_pkg.sv
// -----------------------------------------------------------------------------
// inert_resp_pkg
// Shared definitions for the inertial-sensor SPI responder:
//   - resp_state_t : frame state machine encoding (IDLE, SHIFT, DONE)
//   - ADDR_*       : 7-bit register addresses of the sensor register map
//   - WHO_AM_I_VAL : fixed identification byte
// -----------------------------------------------------------------------------
package inert_resp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } resp_state_t;

   localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
   localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
   localparam logic [6:0] ADDR_CTRL1_XL  = 7'h10;
   localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
   localparam logic [6:0] ADDR_CTRL5     = 7'h14;
   localparam logic [6:0] ADDR_PTCHL     = 7'h22;
   localparam logic [6:0] ADDR_PTCHH     = 7'h23;
   localparam logic [6:0] ADDR_AZL       = 7'h2C;
   localparam logic [6:0] ADDR_AZH       = 7'h2D;

   localparam logic [7:0] WHO_AM_I_VAL   = 8'h6A;

endpackage

// File: rtl/inert_sensor_resp_if.sv
// -----------------------------------------------------------------------------
// inert_sensor_resp_if
// Pin bundle between the SPI master (balance controller / testbench) and the
// sensor responder.
//   SS_n, SCLK, MOSI      : SPI from master (SCLK idles high, MSB first)
//   MISO                  : SPI to master
//   INT                   : data-ready interrupt
//   smpl_vld, ptch_rt_in,
//   az_in                 : sample load strobe and sample values
//   frm_err               : one-cycle pulse on a frame that was not 16 bits
// Handshake: smpl_vld is a single-cycle strobe with no back-pressure; the
// responder always accepts it (deferring the load internally if a frame is
// in flight). SPI is a plain pin-level protocol with no ready signal.
// -----------------------------------------------------------------------------
interface inert_sensor_resp_if;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic        INT;
   logic        smpl_vld;
   logic [15:0] ptch_rt_in;
   logic [15:0] az_in;
   logic        frm_err;

   modport master (
      output SS_n, SCLK, MOSI, smpl_vld, ptch_rt_in, az_in,
      input  MISO, INT, frm_err
   );

   modport slave (
      input  SS_n, SCLK, MOSI, smpl_vld, ptch_rt_in, az_in,
      output MISO, INT, frm_err
   );
endinterface

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchronizer plus a third flop for edge detection.
//   clk    : system clock
//   i_d    : asynchronous pin
//   o_q    : synchronized level (aligned with the edge pulses)
//   o_rise : one-cycle pulse on a 0->1 transition
//   o_fall : one-cycle pulse on a 1->0 transition
// The flops are deliberately not reset: they only track the pin, and a reset
// value differing from the pin would fabricate an edge (e.g. a spurious SS_n
// fall right after a mid-frame reset).
// -----------------------------------------------------------------------------
module spi_sync_edge (
   input  logic clk,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic r_s1, r_s2, r_s3;

   always_ff @(posedge clk) begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
   end

   assign o_q    = r_s2;
   assign o_rise =  r_s2 & ~r_s3;
   assign o_fall = ~r_s2 &  r_s3;

endmodule

// File: rtl/inert_sensor_resp.sv
// -----------------------------------------------------------------------------
// inert_sensor_resp
// SPI responder standing in for the inertial sensor: decodes 16-bit R/W
// frames, holds configuration registers, serves pitch-rate / Z-accel bytes
// and raises INT on a new sample.
//   clk, rst : system clock, synchronous active-high reset
//   io_bus   : inert_sensor_resp_if.slave (SPI pins, sample port, INT, frm_err)
//   o_state  : current frame state (IDLE/SHIFT/DONE encoding of resp_state_t)
// Build option INERT_RESP_AUTOSAMPLE_EN: samples come from an internal ramp
// every SMPL_PERIOD clocks instead of the smpl_vld port.
// -----------------------------------------------------------------------------
module inert_sensor_resp
   import inert_resp_pkg::*;
#(
   parameter int SMPL_PERIOD = 240385
) (
   input  logic                clk,
   input  logic                rst,
   inert_sensor_resp_if.slave  io_bus,
   output logic [1:0]          o_state
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_SHIFT = SHIFT;
   localparam logic [1:0] S_DONE  = DONE;

   logic        w_ss_rise, w_ss_fall, w_sclk_rise, w_sclk_fall, w_mosi;
   logic        w_ss_lvl, w_sclk_lvl, w_mosi_rise, w_mosi_fall;
   logic        w_unused;

   spi_sync_edge u_ss   (.clk(clk), .i_d(io_bus.SS_n), .o_q(w_ss_lvl),
                         .o_rise(w_ss_rise), .o_fall(w_ss_fall));
   spi_sync_edge u_sclk (.clk(clk), .i_d(io_bus.SCLK), .o_q(w_sclk_lvl),
                         .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
   spi_sync_edge u_mosi (.clk(clk), .i_d(io_bus.MOSI), .o_q(w_mosi),
                         .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

   logic [1:0]  r_state;
   logic [15:0] r_rx, r_tx;
   logic [4:0]  r_cnt;
   logic [7:0]  r_int1_ctrl, r_ctrl1_xl, r_ctrl2_g, r_ctrl5;
   logic [31:0] r_hold;       // {ptch_rt, az}
   logic [31:0] r_pend_data;
   logic        r_pend, r_int, r_frm_err;

   logic [15:0] w_rx_next;
   logic [7:0]  w_rd_byte;
   logic        w_smpl;
   logic [31:0] w_smpl_data;
   logic        w_load_now, w_load_pend, w_set_int, w_clr_int, w_frame_ok;

   // ---------------- sample source ----------------
`ifdef INERT_RESP_AUTOSAMPLE_EN
   localparam int CW = $clog2(SMPL_PERIOD);
   localparam logic [CW-1:0] LAST_CNT = CW'(SMPL_PERIOD - 1);
   logic [CW-1:0] r_auto_cnt;
   logic [15:0]   r_ramp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_auto_cnt <= '0;
         r_ramp     <= '0;
      end else if (r_auto_cnt == LAST_CNT) begin
         r_auto_cnt <= '0;
         r_ramp     <= r_ramp + 16'd1;
      end else begin
         r_auto_cnt <= r_auto_cnt + 1'b1;
      end
   end

   assign w_smpl      = (r_auto_cnt == LAST_CNT);
   assign w_smpl_data = {r_ramp, ~r_ramp};
   assign w_unused    = ^{w_ss_lvl, w_sclk_lvl, w_mosi_rise, w_mosi_fall,
                          io_bus.smpl_vld, io_bus.ptch_rt_in, io_bus.az_in};
`else
   assign w_smpl      = io_bus.smpl_vld;
   assign w_smpl_data = {io_bus.ptch_rt_in, io_bus.az_in};
   assign w_unused    = ^{w_ss_lvl, w_sclk_lvl, w_mosi_rise, w_mosi_fall};
`endif

   // ---------------- register read mux ----------------
   assign w_rx_next = {r_rx[14:0], w_mosi};

   always_comb begin
      w_rd_byte = 8'h00;
      case (w_rx_next[6:0])
         ADDR_INT1_CTRL: w_rd_byte = r_int1_ctrl;
         ADDR_WHO_AM_I:  w_rd_byte = WHO_AM_I_VAL;
         ADDR_CTRL1_XL:  w_rd_byte = r_ctrl1_xl;
         ADDR_CTRL2_G:   w_rd_byte = r_ctrl2_g;
         ADDR_CTRL5:     w_rd_byte = r_ctrl5;
         ADDR_PTCHL:     w_rd_byte = r_hold[23:16];
         ADDR_PTCHH:     w_rd_byte = r_hold[31:24];
         ADDR_AZL:       w_rd_byte = r_hold[7:0];
         ADDR_AZH:       w_rd_byte = r_hold[15:8];
         default:        w_rd_byte = 8'h00;
      endcase
   end

   // A sample arriving mid-frame is parked and applied in DONE so a byte
   // already loaded into the transmit shifter is never torn.
   assign w_frame_ok  = (r_cnt == 5'd16);
   assign w_load_now  = w_smpl && (r_state != S_SHIFT);
   assign w_load_pend = r_pend && (r_state == S_DONE);
   assign w_set_int   = (w_load_now || w_load_pend) && r_int1_ctrl[1];
   assign w_clr_int   = (r_state == S_DONE) && w_frame_ok && r_rx[15] &&
                        (r_rx[14:8] == ADDR_PTCHL);

   // ---------------- frame FSM and registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rx        <= '0;
         r_tx        <= '0;
         r_cnt       <= '0;
         r_int1_ctrl <= '0;
         r_ctrl1_xl  <= '0;
         r_ctrl2_g   <= '0;
         r_ctrl5     <= '0;
         r_hold      <= '0;
         r_pend      <= 1'b0;
         r_pend_data <= '0;
         r_int       <= 1'b0;
         r_frm_err   <= 1'b0;
      end else begin
         r_frm_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_ss_fall) begin
                  r_state <= S_SHIFT;
                  r_rx    <= '0;
                  r_cnt   <= '0;
                  r_tx    <= 16'h0000;
               end
            end
            S_SHIFT: begin
               if (w_ss_rise) begin
                  r_state <= S_DONE;
               end else if (w_sclk_rise) begin
                  r_rx <= w_rx_next;
                  if (r_cnt != 5'd31) r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'd7) r_tx[15:8] <= w_rd_byte;
               end else if (w_sclk_fall && (r_cnt != 5'd8)) begin
                  // The fall right after the 8th rise is skipped so the
                  // freshly loaded MSB is presented for the 9th rise.
                  r_tx <= {r_tx[14:0], 1'b0};
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               if (w_frame_ok) begin
                  if (!r_rx[15]) begin
                     case (r_rx[14:8])
                        ADDR_INT1_CTRL: r_int1_ctrl <= r_rx[7:0];
                        ADDR_CTRL1_XL:  r_ctrl1_xl  <= r_rx[7:0];
                        ADDR_CTRL2_G:   r_ctrl2_g   <= r_rx[7:0];
                        ADDR_CTRL5:     r_ctrl5     <= r_rx[7:0];
                        default: ;
                     endcase
                  end
               end else begin
                  r_frm_err <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Sample path: only the most recent deferred sample is kept.
         if (w_smpl && (r_state == S_SHIFT)) begin
            r_pend      <= 1'b1;
            r_pend_data <= w_smpl_data;
         end else if (r_state == S_DONE) begin
            r_pend <= 1'b0;
         end

         if (w_load_now)       r_hold <= w_smpl_data;
         else if (w_load_pend) r_hold <= r_pend_data;

         // Set has priority over the read-of-0x22 clear.
         if (w_set_int)      r_int <= 1'b1;
         else if (w_clr_int) r_int <= 1'b0;
      end
   end

   assign io_bus.MISO    = (r_state == S_SHIFT) ? r_tx[15] : 1'b0;
   assign io_bus.INT     = r_int;
   assign io_bus.frm_err = r_frm_err;
   assign o_state        = r_state;

endmodule

// File: tb/tb_inert_sensor_resp.sv
module tb_inert_sensor_resp;
  import inert_resp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dut_state;
  always #5 clk = ~clk;

  inert_sensor_resp_if bus();

  inert_sensor_resp dut (
    .clk     (clk),
    .rst     (rst),
    .io_bus  (bus),
    .o_state (dut_state)
  );

  // ---------------- bookkeeping ----------------
  int n_pass = 0;
  int n_total = 0;
  int frm_err_cnt = 0;
  logic int_mid;
  logic [15:0] exp_q[$];
  logic [7:0] reg_model [4];
  logic [6:0] rw_addr [4];

  always @(negedge clk) if (bus.frm_err === 1'b1) frm_err_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic spi_xfer(input logic [15:0] frame, input int nbits, input int pulse_bit,
                          input logic [15:0] p_in, input logic [15:0] a_in,
                          input bit end_frame, output logic [15:0] rx_word);
    rx_word = '0;
    @(negedge clk);
    bus.SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.SCLK = 1'b0;
      bus.MOSI = frame[15-i];
      if (i == pulse_bit) begin
        bus.smpl_vld = 1'b1;
        bus.ptch_rt_in = p_in;
        bus.az_in = a_in;
        @(negedge clk);
        bus.smpl_vld = 1'b0;
        repeat (2) @(negedge clk);
        int_mid = bus.INT;
        repeat (5) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      rx_word[15-i] = bus.MISO;
      bus.SCLK = 1'b1;
      repeat (8) @(negedge clk);
    end
    if (end_frame) begin
      repeat (4) @(negedge clk);
      bus.SS_n = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    logic [15:0] dummy;
    spi_xfer({1'b0, addr, data}, 16, -1, 16'h0, 16'h0, 1'b1, dummy);
  endtask

  task automatic spi_read(input logic [6:0] addr, output logic [15:0] word);
    spi_xfer({1'b1, addr, 8'h00}, 16, -1, 16'h0, 16'h0, 1'b1, word);
  endtask

  task automatic pulse_sample(input logic [15:0] p, input logic [15:0] a);
    @(negedge clk);
    bus.smpl_vld = 1'b1;
    bus.ptch_rt_in = p;
    bus.az_in = a;
    @(negedge clk);
    bus.smpl_vld = 1'b0;
    @(negedge clk);
  endtask

  // read an address and compare against the head of the expected queue
  task automatic read_and_score(input logic [6:0] addr, input string name);
    logic [15:0] got, exp;
    spi_read(addr, got);
    exp = exp_q.pop_front();
    n_total++;
    if (got !== exp) $display("FAIL %s: addr=%h got=%h exp=%h", name, addr, got, exp);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.SS_n = 1'b1; bus.SCLK = 1'b1; bus.MOSI = 1'b0;
    bus.smpl_vld = 1'b0; bus.ptch_rt_in = '0; bus.az_in = '0;
    repeat (6) @(negedge clk);
    n_total++; if (bus.MISO !== 1'b0) $display("FAIL reset_miso: got=%b exp=0", bus.MISO); else n_pass++;
    n_total++; if (bus.INT !== 1'b0) $display("FAIL reset_int: got=%b exp=0", bus.INT); else n_pass++;
    n_total++; if (bus.frm_err !== 1'b0) $display("FAIL reset_frm_err: got=%b exp=0", bus.frm_err); else n_pass++;
    n_total++; if (dut_state !== 2'd0) $display("FAIL reset_state: got=%0d exp=0", dut_state); else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(16'h0000);
    read_and_score(ADDR_INT1_CTRL, "reset_int1_ctrl");
  endtask

  task automatic test_whoami();
    exp_q.push_back({8'h00, 8'h6A});
    read_and_score(ADDR_WHO_AM_I, "who_am_i");
    spi_write(ADDR_WHO_AM_I, 8'h11);
    exp_q.push_back({8'h00, 8'h6A});
    read_and_score(ADDR_WHO_AM_I, "who_am_i_readonly");
    spi_write(7'h30, 8'hFF);
    exp_q.push_back(16'h0000);
    read_and_score(7'h30, "unmapped");
  endtask

  task automatic test_write_read();
    spi_write(ADDR_INT1_CTRL, 8'h02);
    exp_q.push_back(16'h0002);
    read_and_score(ADDR_INT1_CTRL, "int1_ctrl_rw");
  endtask

  task automatic test_back_to_back();
    rw_addr[0] = ADDR_CTRL1_XL; rw_addr[1] = ADDR_CTRL2_G;
    rw_addr[2] = ADDR_CTRL5;    rw_addr[3] = ADDR_CTRL1_XL;
    for (int i = 0; i < 4; i++) begin
      reg_model[i] = 8'($urandom_range(1, 255));
      spi_write(rw_addr[i], reg_model[i]);
    end
    // entry 3 overwrote CTRL1_XL; read the three distinct registers
    exp_q.push_back({8'h00, reg_model[3]});
    exp_q.push_back({8'h00, reg_model[1]});
    exp_q.push_back({8'h00, reg_model[2]});
    read_and_score(ADDR_CTRL1_XL, "b2b_ctrl1_xl");
    read_and_score(ADDR_CTRL2_G, "b2b_ctrl2_g");
    read_and_score(ADDR_CTRL5, "b2b_ctrl5");
    spi_write(ADDR_CTRL1_XL, 8'h00);
  endtask

  task automatic test_sample_int();
    pulse_sample(16'h1234, 16'hABCD);
    n_total++; if (bus.INT !== 1'b1) $display("FAIL int_set: got=%b exp=1", bus.INT); else n_pass++;
    exp_q.push_back(16'h0034);
    read_and_score(ADDR_PTCHL, "ptch_low");
    n_total++; if (bus.INT !== 1'b0) $display("FAIL int_clear: got=%b exp=0", bus.INT); else n_pass++;
    exp_q.push_back(16'h0012);
    exp_q.push_back(16'h00CD);
    exp_q.push_back(16'h00AB);
    read_and_score(ADDR_PTCHH, "ptch_high");
    read_and_score(ADDR_AZL, "az_low");
    read_and_score(ADDR_AZH, "az_high");
  endtask

  task automatic test_no_int();
    logic [15:0] p, a;
    p = 16'($urandom_range(0, 65535));
    a = 16'($urandom_range(0, 65535));
    spi_write(ADDR_INT1_CTRL, 8'h00);
    pulse_sample(p, a);
    repeat (3) @(negedge clk);
    n_total++; if (bus.INT !== 1'b0) $display("FAIL no_int: got=%b exp=0", bus.INT); else n_pass++;
    exp_q.push_back({8'h00, p[15:8]});
    exp_q.push_back({8'h00, a[7:0]});
    read_and_score(ADDR_PTCHH, "no_int_ptch_high");
    read_and_score(ADDR_AZL, "no_int_az_low");
    // leave the old high byte for the deferral test
    exp_q.push_back({8'h00, p[15:8]});
  endtask

  task automatic test_deferred_sample();
    logic [15:0] got, exp;
    spi_write(ADDR_INT1_CTRL, 8'h02);
    spi_xfer({1'b1, ADDR_PTCHH, 8'h00}, 16, 12, 16'h5555, 16'h0F0F, 1'b1, got);
    exp = exp_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL defer_old_byte: got=%h exp=%h", got, exp); else n_pass++;
    n_total++; if (int_mid !== 1'b0) $display("FAIL defer_int_mid: got=%b exp=0", int_mid); else n_pass++;
    n_total++; if (bus.INT !== 1'b1) $display("FAIL defer_int_after: got=%b exp=1", bus.INT); else n_pass++;
    exp_q.push_back(16'h0055);
    exp_q.push_back(16'h0055);
    read_and_score(ADDR_PTCHH, "defer_new_high");
    read_and_score(ADDR_PTCHL, "defer_new_low");
  endtask

  task automatic test_frame_error();
    logic [15:0] dummy;
    int base;
    base = frm_err_cnt;
    spi_xfer(16'h1053, 10, -1, 16'h0, 16'h0, 1'b1, dummy);
    n_total++;
    if (frm_err_cnt !== base + 1) $display("FAIL frm_err_pulse: got=%0d exp=%0d", frm_err_cnt - base, 1);
    else n_pass++;
    exp_q.push_back(16'h0000);
    read_and_score(ADDR_CTRL1_XL, "frm_err_no_write");
    n_total++;
    if (frm_err_cnt !== base + 1) $display("FAIL frm_err_good_frame: got=%0d exp=%0d", frm_err_cnt - base, 1);
    else n_pass++;
  endtask

  task automatic test_rst_mid_frame();
    logic [15:0] dummy;
    // 10 bits of a WHO_AM_I read: MISO now carries bit 6 of 0x6A
    spi_xfer({1'b1, ADDR_WHO_AM_I, 8'h00}, 10, -1, 16'h0, 16'h0, 1'b0, dummy);
    n_total++; if (bus.MISO !== 1'b1) $display("FAIL mid_miso: got=%b exp=1", bus.MISO); else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.MISO !== 1'b0) $display("FAIL rst_mid_miso: got=%b exp=0", bus.MISO); else n_pass++;
    n_total++; if (dut_state !== 2'd0) $display("FAIL rst_mid_state: got=%0d exp=0", dut_state); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      bus.SCLK = 1'b0; repeat (8) @(negedge clk);
      bus.SCLK = 1'b1; repeat (8) @(negedge clk);
    end
    n_total++; if (dut_state !== 2'd0) $display("FAIL rst_dangling_state: got=%0d exp=0", dut_state); else n_pass++;
    bus.SS_n = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(16'h0000);
    read_and_score(ADDR_INT1_CTRL, "rst_mid_int1_ctrl");
  endtask

  initial begin
    test_reset();
    test_whoami();
    test_write_read();
    test_back_to_back();
    spi_write(ADDR_INT1_CTRL, 8'h02);
    test_sample_int();
    test_no_int();
    test_deferred_sample();
    test_frame_error();
    test_rst_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
